// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared fifo constants and read-agent FSM state type
package fifo_rd_stream_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read-side and output stream handshake bundle
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = fifo_rd_stream_pkg::FIFO_DATA_WIDTH
);
    logic                  fifo_empty;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop_err;
    logic                  fifo_pop;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    // master: the read agent; slave: the FIFO plus stream consumer around it
    modport master (
        input  fifo_empty, fifo_push, fifo_data, fifo_pop_err, m_ready,
        output fifo_pop, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_push, fifo_data, fifo_pop_err, m_ready,
        input  fifo_pop, m_valid, m_data
    );

endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// rtl/fifo_rd_stream_skid_buf2.sv - 2-entry in-order register buffer; head always in slot 0
module skid_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] e0;
    logic [DATA_WIDTH-1:0] e1;

    assign rd_valid = (occ != 2'd0);
    assign rd_data  = e0;

    // Shifting layout keeps the head in e0 so rd_data needs no read mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (occ == 2'd0) e0 <= wr_data;
                    else             e1 <= wr_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        e0 <= wr_data;
                    end else begin
                        e0 <= e1;
                        e1 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read agent: pop issue, latency absorption, stream output
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    fifo_rd_stream_if.master      rd,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  pop_err_sticky
);

    rd_state_t             state;
    rd_state_t             state_next;
    logic                  inflight;
    logic                  deq;
    logic                  pop;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [1:0]            occ;
    logic [2:0]            occ_after;

    assign deq       = buf_valid && rd.m_ready;
    assign occ_after = {1'b0, occ} + {2'b0, inflight} - {2'b0, deq};

    // Pops are only issued when the FIFO is guaranteed to accept them and a slot
    // is guaranteed free when the data lands one cycle later.
    assign pop = (state == RUN) && en && !rd.fifo_empty && !rd.fifo_push
                 && (occ_after < 3'd2);

    assign rd.fifo_pop = pop;
    assign rd.m_valid  = buf_valid;
    assign rd.m_data   = buf_data;

    assign busy = (state != IDLE) || (occ != 2'd0) || inflight;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (inflight),
        .wr_data  (rd.fifo_data),
        .rd       (deq),
        .rd_valid (buf_valid),
        .rd_data  (buf_data),
        .occ      (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = STOP;
            end
            STOP: begin
                if (en)                               state_next = RUN;
                else if (!inflight && occ == 2'd0)    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight       <= 1'b0;
            words_read     <= '0;
            pop_err_sticky <= 1'b0;
        end else begin
            inflight <= pop;
            if (deq) words_read <= words_read + CNT_WIDTH'(1);
            if (rd.fifo_pop_err) pop_err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench: small FIFO model driving fifo_rd_stream
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          busy;
    logic [CW-1:0] words_read;
    logic          pop_err_sticky;

    logic          push;
    logic [DW-1:0] push_data;
    logic          ext_pop;
    logic          m_ready;

    logic [DW-1:0] mem [8];
    logic [FIFO_ADDR_WIDTH-1:0] wp, rp;
    logic [3:0]    cnt;
    logic [DW-1:0] data_out;
    logic [DW-1:0] got [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) rd ();

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .rd             (rd),
        .busy           (busy),
        .words_read     (words_read),
        .pop_err_sticky (pop_err_sticky)
    );

    // FIFO model: push wins over pop, registered read data, pop-on-empty error
    assign rd.fifo_empty   = (cnt == 4'd0);
    assign rd.fifo_push    = push;
    assign rd.fifo_data    = data_out;
    assign rd.fifo_pop_err = (rd.fifo_pop || ext_pop) && !push && (cnt == 4'd0);
    assign rd.m_ready      = m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; cnt <= '0; data_out <= '0;
        end else if (push && cnt != 4'd8) begin
            mem[wp] <= push_data;
            wp      <= wp + 1'b1;
            cnt     <= cnt + 4'd1;
        end else if ((rd.fifo_pop || ext_pop) && cnt != 4'd0) begin
            data_out <= mem[rp];
            rp       <= rp + 1'b1;
            cnt      <= cnt - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && rd.m_valid && rd.m_ready) got.push_back(rd.m_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            push      = 1'b1;
            push_data = first + DW'(i);
        end
        step();
        push = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; push = 1'b0; push_data = '0; ext_pop = 1'b0; m_ready = 1'b0;
        #3;
        check("rst fifo_pop", rd.fifo_pop, 0);
        check("rst m_valid", rd.m_valid, 0);
        check("rst m_data", rd.m_data, 0);
        check("rst busy", busy, 0);
        check("rst words_read", words_read, 0);
        check("rst sticky", pop_err_sticky, 0);
        #9 rst_n = 1'b1;

        // 1. burst
        step(); push = 1; push_data = 8'h11; en = 1; m_ready = 1; #1;
        check("t1 pop idle", rd.fifo_pop, 0);
        step(); push_data = 8'h22; #1;
        check("t1 pop vs push a", rd.fifo_pop, 0);
        step(); push_data = 8'h33; #1;
        check("t1 pop vs push b", rd.fifo_pop, 0);
        step(); push = 0; #1;
        check("t1 first pop", rd.fifo_pop, 1);
        step(); #1;
        check("t1 valid before data", rd.m_valid, 0);
        check("t1 second pop", rd.fifo_pop, 1);
        step(); #1;
        check("t1 valid d0", rd.m_valid, 1);
        check("t1 data d0", rd.m_data, 8'h11);
        step(); #1;
        check("t1 data d1", rd.m_data, 8'h22);
        check("t1 no pop empty", rd.fifo_pop, 0);
        step(); #1;
        check("t1 data d2", rd.m_data, 8'h33);
        step(); en = 0; #1;
        check("t1 words_read", words_read, 3);
        check("t1 drained", rd.m_valid, 0);
        step(2); #1;
        check("t1 busy", busy, 0);

        // 2. push collision
        step(); push = 1; push_data = 8'hA5; #1;
        step(); push = 0; en = 1; #1;
        step(); push = 1; push_data = 8'h5A; #1;
        check("t2 collision pop", rd.fifo_pop, 0);
        step(); push = 0; #1;
        check("t2 deferred pop", rd.fifo_pop, 1);
        step(); #1;
        check("t2 pop second", rd.fifo_pop, 1);
        step(); #1;
        check("t2 data a5", rd.m_data, 8'hA5);
        check("t2 valid a5", rd.m_valid, 1);
        step(); #1;
        check("t2 data 5a", rd.m_data, 8'h5A);
        step(); en = 0; #1;
        check("t2 sticky", pop_err_sticky, 0);
        check("t2 words_read", words_read, 5);
        step(2);

        // 3. backpressure
        got.delete();
        m_ready = 0;
        push_seq(8'hC1, 4);
        en = 1;
        step(4); #1;
        check("t3 valid", rd.m_valid, 1);
        check("t3 head", rd.m_data, 8'hC1);
        check("t3 pop blocked", rd.fifo_pop, 0);
        check("t3 fifo left", cnt, 2);
        step(3); #1;
        check("t3 head stable", rd.m_data, 8'hC1);
        check("t3 still blocked", rd.fifo_pop, 0);
        m_ready = 1;
        step(8); #1;
        check("t3 count", got.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3 order %0d", i), got[i], 8'hC1 + i);
        check("t3 words_read", words_read, 9);
        en = 0;
        step(3);

        // 4. stop while a pop is in flight
        got.delete();
        push_seq(8'hD1, 3);
        en = 1; #1;
        check("t4 idle no pop", rd.fifo_pop, 0);
        step(); #1;
        check("t4 pop", rd.fifo_pop, 1);
        step(); en = 0; #1;
        check("t4 stop no pop", rd.fifo_pop, 0);
        check("t4 busy inflight", busy, 1);
        step(); #1;
        check("t4 inflight delivered", rd.m_data, 8'hD1);
        check("t4 valid", rd.m_valid, 1);
        step(2); #1;
        check("t4 state idle", dut.state, IDLE);
        check("t4 busy", busy, 0);
        check("t4 fifo retains", cnt, 2);
        check("t4 got one", got.size(), 1);
        en = 1;
        step(8);
        en = 0;
        step(3);
        check("t4 got all", got.size(), 3);
        check("t4 d2", got[1], 8'hD2);
        check("t4 d3", got[2], 8'hD3);
        check("t4 words_read", words_read, 12);

        // counter wrap: 12 + 5 = 17 -> 1 with a 4-bit counter
        got.delete();
        push_seq(8'h01, 5);
        en = 1;
        step(10);
        en = 0;
        step(3);
        check("wrap count", got.size(), 5);
        check("wrap last", got[4], 8'h05);
        check("wrap words_read", words_read, 1);

        // 5. error latch
        step(); ext_pop = 1; #1;
        check("t5 sticky before", pop_err_sticky, 0);
        step(); ext_pop = 0; #1;
        check("t5 sticky set", pop_err_sticky, 1);
        step(5); #1;
        check("t5 sticky holds", pop_err_sticky, 1);

        // 6. reset mid-stream
        m_ready = 0;
        push_seq(8'hE1, 3);
        en = 1;
        step(6); #1;
        check("t6 valid pre", rd.m_valid, 1);
        check("t6 head pre", rd.m_data, 8'hE1);
        check("t6 full no pop", rd.fifo_pop, 0);
        #2 rst_n = 0; #1;
        check("t6 async valid", rd.m_valid, 0);
        check("t6 async words", words_read, 0);
        check("t6 async sticky", pop_err_sticky, 0);
        check("t6 async busy", busy, 0);
        step(2);
        rst_n = 1; m_ready = 1;
        step(4); #1;
        check("t6 empty no pop", rd.fifo_pop, 0);
        check("t6 empty no valid", rd.m_valid, 0);
        got.delete();
        step(); push = 1; push_data = 8'hF0;
        step(); push = 0;
        step(5);
        check("t6 resume count", got.size(), 1);
        check("t6 resume data", got[0], 8'hF0);
        check("t6 resume words", words_read, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
